// File: rtl/bus_router_pkg.sv
// Shared types, constants and helpers for the N-slave bus router.
package bus_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_router_nslave_if.sv
// Master-side request/response bus plus the fanned-out slave ports.
interface bus_router_nslave_if #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
);

  logic                         req_in;
  logic [ADDR_W-1:0]            addr_in;
  logic                         cmd_in;
  logic [DATA_W-1:0]            wdata_in;
  logic                         ack_in;
  logic [DATA_W-1:0]            rdata_in;
  logic                         err_in;

  logic [N_SLAVES-1:0]          req_out;
  logic [N_SLAVES*ADDR_W-1:0]   addr_out;
  logic [N_SLAVES-1:0]          cmd_out;
  logic [N_SLAVES*DATA_W-1:0]   wdata_out;
  logic [N_SLAVES-1:0]          ack_out;
  logic [N_SLAVES*DATA_W-1:0]   rdata_out;

  // Environment view: drives master requests and slave responses.
  modport master (
    output req_in, addr_in, cmd_in, wdata_in, ack_out, rdata_out,
    input  ack_in, rdata_in, err_in, req_out, addr_out, cmd_out, wdata_out
  );

  // Router view: serves the master and drives the slave ports.
  modport slave (
    input  req_in, addr_in, cmd_in, wdata_in, ack_out, rdata_out,
    output ack_in, rdata_in, err_in, req_out, addr_out, cmd_out, wdata_out
  );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Saturating transaction-age counter with a registered expiry flag.
module bus_timeout_cnt
  import bus_router_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (clog2(LIMIT + 1) == 0) ? 1 : clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Clear wins over count; the count parks at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d == CNT_LIMIT);
  end

  // Count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/bus_router_nslave.sv
// Registered 1-to-N bus router: captures a master transaction, holds it on the
// addressed slave until ack or timeout, then returns a one-cycle response.
module bus_router_nslave
  import bus_router_pkg::*;
#(
  parameter int unsigned N_SLAVES    = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  bus_router_nslave_if.slave bus
);

  localparam int unsigned SEL_W = clog2(N_SLAVES);
  localparam logic [DATA_W-1:0] ERR_DATA_W = DATA_W'(ERR_DATA);

  state_e                     state_q, state_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [N_SLAVES-1:0]        req_out_q, req_out_d;
  logic [N_SLAVES*ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [N_SLAVES-1:0]        cmd_out_q, cmd_out_d;
  logic [N_SLAVES*DATA_W-1:0] wdata_out_q, wdata_out_d;
  logic                       ack_in_q, ack_in_d;
  logic [DATA_W-1:0]          rdata_in_q, rdata_in_d;
  logic                       err_in_q, err_in_d;

  logic [SEL_W-1:0]           req_sel_c;
  logic                       cnt_clr, cnt_en, cnt_expired;

  assign req_sel_c = bus.addr_in[ADDR_W-1 -: SEL_W];

  // Timeout counter, absent when the timeout is disabled.
  if (TIMEOUT_CYC != 0) begin : g_timeout
    bus_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .expired (cnt_expired)
    );
  end else begin : g_no_timeout
    assign cnt_expired = 1'b0;
  end

  // Next state and next registered outputs; ack beats expiry in the same cycle.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    req_out_d   = req_out_q;
    addr_out_d  = addr_out_q;
    cmd_out_d   = cmd_out_q;
    wdata_out_d = wdata_out_q;
    ack_in_d    = 1'b0;
    rdata_in_d  = '0;
    err_in_d    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_in) begin
          sel_d                                         = req_sel_c;
          req_out_d                                     = '0;
          req_out_d[req_sel_c]                          = 1'b1;
          addr_out_d                                    = '0;
          addr_out_d[ADDR_W*32'(req_sel_c) +: ADDR_W]   = bus.addr_in;
          cmd_out_d                                     = '0;
          cmd_out_d[req_sel_c]                          = bus.cmd_in;
          wdata_out_d                                   = '0;
          wdata_out_d[DATA_W*32'(req_sel_c) +: DATA_W]  = bus.wdata_in;
          cnt_clr                                       = 1'b1;
          state_d                                       = BUSY;
        end
      end

      BUSY: begin
        cnt_en = 1'b1;
        if (bus.ack_out[sel_q]) begin
          ack_in_d   = 1'b1;
          rdata_in_d = (cmd_out_q[sel_q] == CMD_WRITE) ? '0
                       : bus.rdata_out[DATA_W*32'(sel_q) +: DATA_W];
          req_out_d  = '0;
          state_d    = RESP;
        end else if (cnt_expired) begin
          ack_in_d   = 1'b1;
          rdata_in_d = ERR_DATA_W;
          err_in_d   = 1'b1;
          req_out_d  = '0;
          state_d    = RESP;
        end
      end

      RESP: begin
        req_out_d   = '0;
        addr_out_d  = '0;
        cmd_out_d   = '0;
        wdata_out_d = '0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      req_out_q   <= '0;
      addr_out_q  <= '0;
      cmd_out_q   <= '0;
      wdata_out_q <= '0;
      ack_in_q    <= 1'b0;
      rdata_in_q  <= '0;
      err_in_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      req_out_q   <= req_out_d;
      addr_out_q  <= addr_out_d;
      cmd_out_q   <= cmd_out_d;
      wdata_out_q <= wdata_out_d;
      ack_in_q    <= ack_in_d;
      rdata_in_q  <= rdata_in_d;
      err_in_q    <= err_in_d;
    end
  end

  assign bus.req_out   = req_out_q;
  assign bus.addr_out  = addr_out_q;
  assign bus.cmd_out   = cmd_out_q;
  assign bus.wdata_out = wdata_out_q;
  assign bus.ack_in    = ack_in_q;
  assign bus.rdata_in  = rdata_in_q;
  assign bus.err_in    = err_in_q;

endmodule

// File: tb/tb_bus_router_nslave.sv
// Directed bench for bus_router_nslave with a transaction-level reference model.
module tb_bus_router_nslave;

  localparam int unsigned NS  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_router_nslave_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_router_nslave #(
    .N_SLAVES    (NS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction and its pending response.
  bit          m_busy, m_resp, m_cmd, m_err;
  int          m_sel, m_age;
  logic [31:0] m_addr, m_wdata, m_rdata;

  initial begin
    logic [127:0] e_addr, e_wdata;
    logic [3:0]   e_req, e_cmd;
    m_busy = 0; m_resp = 0; m_cmd = 0; m_err = 0;
    m_sel = 0; m_age = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0;
        m_resp = 0;
      end else if (m_resp) begin
        m_resp = 0;
      end else if (m_busy) begin
        if (bus.ack_out[m_sel]) begin
          m_resp  = 1;
          m_err   = 0;
          m_rdata = m_cmd ? 32'h0 : bus.rdata_out[m_sel*32 +: 32];
          m_busy  = 0;
        end else if (m_age == int'(TMO)) begin
          m_resp  = 1;
          m_err   = 1;
          m_rdata = 32'hDEAD_BEEF;
          m_busy  = 0;
        end else begin
          m_age++;
        end
      end else if (bus.req_in) begin
        m_busy  = 1;
        m_sel   = int'(bus.addr_in[31:30]);
        m_addr  = bus.addr_in;
        m_cmd   = bus.cmd_in;
        m_wdata = bus.wdata_in;
        m_age   = 0;
      end
      #1;
      e_req = m_busy ? 4'(1 << m_sel) : 4'b0000;
      e_cmd = (m_busy && m_cmd) ? 4'(1 << m_sel) : 4'b0000;
      e_addr = '0;
      e_wdata = '0;
      if (m_busy) begin
        e_addr[m_sel*32 +: 32]  = m_addr;
        e_wdata[m_sel*32 +: 32] = m_wdata;
      end
      check("model_ack_in",   128'(bus.ack_in),   128'(m_resp));
      check("model_rdata_in", 128'(bus.rdata_in), 128'(m_resp ? m_rdata : 32'h0));
      check("model_err_in",   128'(bus.err_in),   128'(m_resp ? m_err : 1'b0));
      check("model_req_out",  128'(bus.req_out),  128'(e_req));
      if (!m_resp) begin
        check("model_addr_out",  bus.addr_out,      e_addr);
        check("model_cmd_out",   128'(bus.cmd_out), 128'(e_cmd));
        check("model_wdata_out", bus.wdata_out,     e_wdata);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic master_req(input logic [31:0] a, input logic c, input logic [31:0] wd);
    bus.req_in   = 1'b1;
    bus.addr_in  = a;
    bus.cmd_in   = c;
    bus.wdata_in = wd;
  endtask

  task automatic master_idle();
    bus.req_in   = 1'b0;
    bus.addr_in  = '0;
    bus.cmd_in   = 1'b0;
    bus.wdata_in = '0;
  endtask

  task automatic slave_ack(input int s, input logic [31:0] rd);
    bus.ack_out   = 4'(1 << s);
    bus.rdata_out = '0;
    bus.rdata_out[s*32 +: 32] = rd;
  endtask

  task automatic slave_quiet();
    bus.ack_out   = '0;
    bus.rdata_out = '0;
  endtask

  task automatic expect_ack(input string name, input logic [31:0] rd, input logic err);
    check({name, "_ack_in"},   128'(bus.ack_in),   128'(1'b1));
    check({name, "_rdata_in"}, 128'(bus.rdata_in), 128'(rd));
    check({name, "_err_in"},   128'(bus.err_in),   128'(err));
  endtask

  initial begin
    int n_hi;
    rst = 1'b1;
    master_idle();
    slave_quiet();

    // Reset state.
    step(2);
    check("rst_req_out",  128'(bus.req_out), 128'(4'b0000));
    check("rst_ack_in",   128'(bus.ack_in),  128'(1'b0));
    check("rst_addr_out", bus.addr_out,      128'(0));
    rst = 1'b0;
    step();

    // Read routed to slave 2, slave acks two cycles after seeing the request.
    master_req(32'h8000_0010, 1'b0, 32'h0);
    step();
    check("rd_req_out",     128'(bus.req_out),        128'(4'b0100));
    check("rd_addr_slice2", 128'(bus.addr_out[95:64]), 128'(32'h8000_0010));
    check("rd_addr_others", 128'({bus.addr_out[127:96], bus.addr_out[63:0]}), 128'(0));
    step(2);
    slave_ack(2, 32'h1234_5678);
    step();
    slave_quiet();
    expect_ack("rd", 32'h1234_5678, 1'b0);
    check("rd_req_dropped", 128'(bus.req_out), 128'(4'b0000));
    master_idle();
    step();
    check("rd_ack_one_cycle", 128'(bus.ack_in), 128'(1'b0));

    // Write routed to slave 3; write returns zero data even if the slave drives some.
    master_req(32'hC000_0004, 1'b1, 32'hA5A5_A5A5);
    step();
    check("wr_req_out",      128'(bus.req_out),           128'(4'b1000));
    check("wr_cmd_out",      128'(bus.cmd_out),           128'(4'b1000));
    check("wr_wdata_slice3", 128'(bus.wdata_out[127:96]), 128'(32'hA5A5_A5A5));
    check("wr_wdata_others", 128'(bus.wdata_out[95:0]),   128'(0));
    check("wr_addr_slice3",  128'(bus.addr_out[127:96]),  128'(32'hC000_0004));
    slave_ack(3, 32'hFFFF_FFFF);
    step();
    slave_quiet();
    expect_ack("wr", 32'h0, 1'b0);
    master_idle();
    step();

    // Timeout on slave 1, then late acks are ignored.
    master_req(32'h4000_0020, 1'b0, 32'h0);
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.ack_in) break;
      if (bus.req_out == 4'b0010) n_hi++;
    end
    check("tmo_req_cycles", 128'(n_hi), 128'(9));
    expect_ack("tmo", 32'hDEAD_BEEF, 1'b1);
    master_idle();
    slave_ack(1, 32'h7777_7777);
    step();
    slave_quiet();
    check("tmo_late_ack_resp", 128'(bus.ack_in), 128'(1'b0));
    slave_ack(1, 32'h7777_7777);
    step();
    slave_quiet();
    check("tmo_late_ack_idle", 128'(bus.ack_in), 128'(1'b0));
    step();
    check("tmo_late_ack_idle2", 128'(bus.ack_in),  128'(1'b0));
    check("tmo_late_req_out",   128'(bus.req_out), 128'(4'b0000));

    // Stray ack from slave 0 while slave 3 is selected.
    master_req(32'hC000_0000, 1'b0, 32'h0);
    step();
    slave_ack(0, 32'h0BAD_0BAD);
    step();
    slave_quiet();
    check("stray_no_ack",  128'(bus.ack_in),  128'(1'b0));
    check("stray_req_out", 128'(bus.req_out), 128'(4'b1000));
    slave_ack(3, 32'h3333_0003);
    step();
    slave_quiet();
    expect_ack("stray", 32'h3333_0003, 1'b0);
    master_idle();
    step();

    // Back-to-back: next request presented right after the response.
    master_req(32'h8000_0000, 1'b0, 32'h0);
    step();
    slave_ack(2, 32'h2222_0002);
    step();
    slave_quiet();
    expect_ack("b2b_first", 32'h2222_0002, 1'b0);
    master_req(32'h0000_0100, 1'b0, 32'h0);
    step();
    check("b2b_gap_req_out", 128'(bus.req_out), 128'(4'b0000));
    check("b2b_gap_ack_in",  128'(bus.ack_in),  128'(1'b0));
    step();
    check("b2b_req_out",     128'(bus.req_out),        128'(4'b0001));
    check("b2b_addr_slice0", 128'(bus.addr_out[31:0]), 128'(32'h0000_0100));
    slave_ack(0, 32'h0000_00A0);
    step();
    slave_quiet();
    expect_ack("b2b_second", 32'h0000_00A0, 1'b0);
    master_idle();
    step();

    // Ack in the same cycle as timeout expiry: the ack wins.
    master_req(32'h0000_0040, 1'b0, 32'h0);
    step();
    step(8);
    check("sim_still_req", 128'(bus.req_out), 128'(4'b0001));
    slave_ack(0, 32'h5151_0009);
    step();
    slave_quiet();
    expect_ack("sim", 32'h5151_0009, 1'b0);
    master_idle();
    step();

    // Reset held two cycles in the middle of a transaction to slave 2.
    master_req(32'h8000_0000, 1'b0, 32'h0);
    step();
    check("mrst_req_before", 128'(bus.req_out), 128'(4'b0100));
    rst = 1'b1;
    step();
    check("mrst_req_out",  128'(bus.req_out),   128'(4'b0000));
    check("mrst_addr_out", bus.addr_out,        128'(0));
    check("mrst_cmd_out",  128'(bus.cmd_out),   128'(4'b0000));
    check("mrst_ack_in",   128'(bus.ack_in),    128'(1'b0));
    step();
    master_idle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mrst_no_ack_after", 128'(bus.ack_in),  128'(1'b0));
      check("mrst_req_after",    128'(bus.req_out), 128'(4'b0000));
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
